spi_cmd_arbiter: RTL



---
 rtl/spi_arb_pkg.sv | 29 ++
 rtl/spi_rr_pick.sv | 28 ++
 rtl/spi_cmd_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state type and sizing constants
// for the SPI command arbiter and its round-robin picker.
package spi_arb_pkg;

  localparam int SPI_ARB_MAX_REQ = 8;
  localparam int SPI_ARB_IDX_W   = 3;
  localparam int SPI_ARB_TMO_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK,
    S_LOCKED
  } spi_arb_state_e;

  function automatic logic [SPI_ARB_IDX_W-1:0] oh2idx(
    input logic [SPI_ARB_MAX_REQ-1:0] oh
  );
    logic [SPI_ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int j = 0; j < SPI_ARB_MAX_REQ; j++) begin
      if (oh[j]) idx = SPI_ARB_IDX_W'(j);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin one-hot pick,
// searching upward from the requester after the last owner.
import spi_arb_pkg::*;

module spi_rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]       req,
  input  logic [SPI_ARB_IDX_W-1:0] last,
  output logic [NUM_REQ-1:0]       pick
);

  always_comb begin
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] &&
            j == (int'(last) + i) % NUM_REQ) begin
          pick[j] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter: shares one SPI master between requesters
// with round-robin grant and lock. Watchdog: SPI_ARB_TIMEOUT_EN.
import spi_arb_pkg::*;

module spi_cmd_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ-1:0]           i_req_rd,
  input  logic [NUM_REQ-1:0]           i_req_lock,
  input  logic [NUM_REQ*MOSI_DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [NUM_REQ-1:0]           o_req_ack,
  output logic [NUM_REQ-1:0]           o_req_err,
  output logic [MISO_DATA_WIDTH-1:0]   o_rd_data,
  output logic                         o_spi_wr_cmd,
  output logic                         o_spi_rd_cmd,
  output logic [MOSI_DATA_WIDTH-1:0]   o_spi_wr_data,
  input  logic [MISO_DATA_WIDTH-1:0]   i_spi_rd_data,
  input  logic                         i_spi_busy
);

  localparam int MW = MOSI_DATA_WIDTH;
  localparam int DW = MISO_DATA_WIDTH;

  spi_arb_state_e state_q, state_n;

  logic [NUM_REQ-1:0]       grant_q, grant_n, pick;
  logic [NUM_REQ-1:0]       ack_q, ack_n, err_q, err_n;
  logic [SPI_ARB_IDX_W-1:0] last_q, last_n;
  logic [MW-1:0]            word_q, word_n;
  logic [MW-1:0]            pick_word, own_word;
  logic [DW-1:0]            rd_data_q, rd_data_n;
  logic rd_q, rd_n;
  logic wr_cmd_q, wr_cmd_n, rd_cmd_q, rd_cmd_n;
  logic pick_rd, own_rd, own_req, own_lock;
  logic tmo_hit;

  spi_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req (i_req),
    .last(last_q),
    .pick(pick)
  );

  assign pick_rd  = |(pick & i_req_rd);
  assign own_rd   = |(grant_q & i_req_rd);
  assign own_req  = |(grant_q & i_req);
  assign own_lock = |(grant_q & i_req_lock);

  always_comb begin
    pick_word = '0;
    own_word  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k])
        pick_word = i_req_data[k*MW +: MW];
      if (grant_q[k])
        own_word = i_req_data[k*MW +: MW];
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [SPI_ARB_TMO_W-1:0] TMO_LAST =
    SPI_ARB_TMO_W'(TIMEOUT_CYCLES - 1);

  logic [SPI_ARB_TMO_W-1:0] tmo_cnt;
  logic                     tmo_run;

  assign tmo_run = (state_q == S_WAIT_BUSY) ||
                   (state_q == S_WAIT_DONE) ||
                   (state_q == S_LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (state_n != state_q)
      tmo_cnt <= '0;
    else if (tmo_run)
      tmo_cnt <= tmo_cnt + SPI_ARB_TMO_W'(1);
  end

  assign tmo_hit = tmo_run && (tmo_cnt == TMO_LAST);
`else
  logic unused_tmo;
  assign unused_tmo = ^SPI_ARB_TMO_W'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_n   = state_q;
    grant_n   = grant_q;
    last_n    = last_q;
    word_n    = word_q;
    rd_n      = rd_q;
    rd_data_n = rd_data_q;
    ack_n     = '0;
    err_n     = '0;
    wr_cmd_n  = 1'b0;
    rd_cmd_n  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|i_req && !i_spi_busy) begin
          grant_n = pick;
          last_n  = oh2idx(SPI_ARB_MAX_REQ'(pick));
          word_n  = pick_word;
          rd_n    = pick_rd;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wr_cmd_n = !rd_q;
        rd_cmd_n = rd_q;
        state_n  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_spi_busy) begin
          state_n = S_WAIT_DONE;
        end else if (tmo_hit) begin
          ack_n   = grant_q;
          err_n   = grant_q;
          grant_n = '0;
          word_n  = '0;
          state_n = S_IDLE;
        end
      end
      // ack is launched here so it lands one cycle after busy falls
      S_WAIT_DONE: begin
        if (!i_spi_busy) begin
          ack_n   = grant_q;
          if (rd_q) rd_data_n = i_spi_rd_data;
          state_n = S_ACK;
        end else if (tmo_hit) begin
          ack_n   = grant_q;
          err_n   = grant_q;
          grant_n = '0;
          word_n  = '0;
          state_n = S_IDLE;
        end
      end
      S_ACK: begin
        if (own_lock) begin
          state_n = S_LOCKED;
        end else begin
          grant_n = '0;
          word_n  = '0;
          state_n = S_IDLE;
        end
      end
      // locked owner re-issues straight away, skipping arbitration
      S_LOCKED: begin
        if (own_req) begin
          word_n   = own_word;
          rd_n     = own_rd;
          wr_cmd_n = !own_rd;
          rd_cmd_n = own_rd;
          state_n  = S_WAIT_BUSY;
        end else if (!own_lock) begin
          grant_n = '0;
          word_n  = '0;
          state_n = S_IDLE;
        end else if (tmo_hit) begin
          ack_n   = grant_q;
          err_n   = grant_q;
          grant_n = '0;
          word_n  = '0;
          state_n = S_IDLE;
        end
      end
      default: begin
        grant_n = '0;
        word_n  = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      last_q    <= SPI_ARB_IDX_W'(NUM_REQ - 1);
      word_q    <= '0;
      rd_q      <= 1'b0;
      rd_data_q <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      wr_cmd_q  <= 1'b0;
      rd_cmd_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      grant_q   <= grant_n;
      last_q    <= last_n;
      word_q    <= word_n;
      rd_q      <= rd_n;
      rd_data_q <= rd_data_n;
      ack_q     <= ack_n;
      err_q     <= err_n;
      wr_cmd_q  <= wr_cmd_n;
      rd_cmd_q  <= rd_cmd_n;
    end
  end

  assign o_grant       = grant_q;
  assign o_req_ack     = ack_q;
  assign o_req_err     = err_q;
  assign o_rd_data     = rd_data_q;
  assign o_spi_wr_cmd  = wr_cmd_q;
  assign o_spi_rd_cmd  = rd_cmd_q;
  assign o_spi_wr_data = word_q;

endmodule
